// File: rtl/bus_ctrl_pkg.sv
// Bus controller types: FSM states, core count and request-class encoding.
package bus_ctrl_pkg;

  // Only a two-core system is supported; the "other" core is always ~grant.
  localparam int NUM_CPUS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    WB     = 3'd2,
    SNOOP  = 3'd3,
    MEMRD  = 3'd4,
    C2C    = 3'd5,
    INVAL  = 3'd6
  } bus_state_t;

  // Which request vector won arbitration in IDLE.
  typedef enum logic [1:0] {
    REQ_NONE   = 2'd0,
    REQ_ICLASS = 2'd1,
    REQ_DCLASS = 2'd2
  } req_class_t;

  // Entry state for a granted d-class request: writeback beats a miss
  // fetch, which beats a pure upgrade (write intent on a shared copy).
  function automatic bus_state_t d_entry_state(input logic dwen,
                                               input logic dren,
                                               input logic upgrade);
    if (dwen)         return WB;
    else if (dren)    return SNOOP;
    else if (upgrade) return INVAL;
    else              return IDLE;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: the RAM handshake state seen by the bus.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Any d-class request beats all i-class
// requests; within the winning class a tie goes to the core that was not
// served last. The last pointer moves only when a transaction finishes.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic [1:0] i_dreq,
  input  logic [1:0] i_ireq,
  input  logic       i_done,
  input  logic       i_done_idx,
  output logic       o_valid,
  output logic       o_grant,
  output logic       o_dclass
);

  logic       r_last;
  logic [1:0] w_vec;

  // Pick the winning class, then the core within it.
  always_comb begin
    o_dclass = |i_dreq;
    w_vec    = o_dclass ? i_dreq : i_ireq;
    o_valid  = |w_vec;
    if (&w_vec) o_grant = ~r_last;
    else        o_grant = w_vec[1];
  end

  // Last-served pointer; reset to 1 so core 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_nrst)     r_last <= 1'b1;
    else if (i_done) r_last <= i_done_idx;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Dual-core bus controller: arbitrates icache/dcache traffic onto one RAM
// port and runs the MSI snoop sequence (snoop broadcast, invalidate,
// cache-to-cache transfer with concurrent RAM writeback).
//
// Handshake: RAM strobes, address and data are combinational from the
// granted core's live request signals and stay asserted until ramstate is
// ACCESS; a word completes only in an ACCESS cycle, which is signalled to
// the core by pulling its iwait/dwait low for exactly that cycle. The core
// then advances its address/data (or drops its request) after that edge.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
  import bus_ctrl_pkg::*;
#(
  parameter int CPUS = NUM_CPUS
) (
  input  logic                   CLK,
  input  logic                   nRST,
  // icache side
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0][31:0]  iload,
  // dcache side
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  // coherence
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  // RAM
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  ramstate_t              ramstate,
  // debug
  output bus_state_t             o_dbg_state
);

  bus_state_t r_state, w_next_state;
  logic       r_g, w_g_next;
  logic       r_w, w_w_next;

  logic [CPUS-1:0] w_dreq;
  logic            w_o;
  logic            w_done;
  logic            w_block_xfer;
  logic            w_arb_valid, w_arb_grant, w_arb_dclass;
  req_class_t      w_req_class;

  assign w_o         = ~r_g;
  assign o_dbg_state = r_state;

  // d-class request: block read, block writeback or upgrade.
  always_comb begin
    w_dreq = dREN | dWEN | (cctrans & ccwrite);
  end

  rr_arbiter2 u_arb (
    .i_clk      (CLK),
    .i_nrst     (nRST),
    .i_dreq     (w_dreq),
    .i_ireq     (iREN),
    .i_done     (w_done),
    .i_done_idx (r_g),
    .o_valid    (w_arb_valid),
    .o_grant    (w_arb_grant),
    .o_dclass   (w_arb_dclass)
  );

  // Classify the arbitration result.
  always_comb begin
    if (!w_arb_valid)     w_req_class = REQ_NONE;
    else if (w_arb_dclass) w_req_class = REQ_DCLASS;
    else                   w_req_class = REQ_ICLASS;
  end

  // State, grant and word-counter registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_g     <= 1'b0;
      r_w     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_g     <= w_g_next;
      r_w     <= w_w_next;
    end
  end

  // Next-state and output decode; every output defaults to idle values.
  always_comb begin
    w_next_state = r_state;
    w_g_next     = r_g;
    w_w_next     = r_w;
    w_done       = 1'b0;
    w_block_xfer = 1'b0;
    iwait        = '1;
    dwait        = '1;
    iload        = '0;
    dload        = '0;
    ccwait       = '0;
    ccinv        = '0;
    ccsnoopaddr  = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    case (r_state)
      IDLE: begin
        w_w_next = 1'b0;
        case (w_req_class)
          REQ_DCLASS: begin
            w_g_next     = w_arb_grant;
            w_next_state = d_entry_state(dWEN[w_arb_grant], dREN[w_arb_grant],
                                         cctrans[w_arb_grant] & ccwrite[w_arb_grant]);
          end
          REQ_ICLASS: begin
            w_g_next     = w_arb_grant;
            w_next_state = IFETCH;
          end
          default: ;
        endcase
      end

      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[r_g];
        iload[r_g] = ramload;
        if (ramstate == ACCESS) begin
          iwait[r_g]   = 1'b0;
          w_next_state = IDLE;
          w_done       = 1'b1;
        end
      end

      WB: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[r_g];
        ramstore     = dstore[r_g];
        w_block_xfer = 1'b1;
      end

      SNOOP: begin
        ccwait[w_o]      = 1'b1;
        ccsnoopaddr[w_o] = daddr[r_g];
        ccinv[w_o]       = ccwrite[r_g];
        w_next_state     = cctrans[w_o] ? C2C : MEMRD;
      end

      MEMRD: begin
        ccwait[w_o]      = 1'b1;
        ccsnoopaddr[w_o] = daddr[r_g];
        ccinv[w_o]       = ccwrite[r_g];
        ramREN           = 1'b1;
        ramaddr          = daddr[r_g];
        dload[r_g]       = ramload;
        w_block_xfer     = 1'b1;
      end

      C2C: begin
        // The snooped core supplies the block; RAM is written in parallel.
        ccwait[w_o]      = 1'b1;
        ccsnoopaddr[w_o] = daddr[r_g];
        ccinv[w_o]       = ccwrite[r_g];
        ramWEN           = 1'b1;
        ramaddr          = daddr[r_g];
        ramstore         = dstore[w_o];
        dload[r_g]       = dstore[w_o];
        w_block_xfer     = 1'b1;
      end

      INVAL: begin
        ccwait[w_o]      = 1'b1;
        ccinv[w_o]       = 1'b1;
        ccsnoopaddr[w_o] = daddr[r_g];
        w_next_state     = IDLE;
        w_done           = 1'b1;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    // Two-word block transfers: count completed words, finish after word 1.
    if (w_block_xfer && (ramstate == ACCESS)) begin
      dwait[r_g] = 1'b0;
      if (r_w) begin
        w_w_next     = 1'b0;
        w_next_state = IDLE;
        w_done       = 1'b1;
      end else begin
        w_w_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with a behavioural RAM model
// (programmable wait states, optional ERROR instead of BUSY while waiting).
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;
  import bus_ctrl_pkg::*;

  logic              CLK, nRST;
  logic [1:0]        iREN, iwait, dREN, dWEN, dwait;
  logic [1:0]        cctrans, ccwrite, ccwait, ccinv;
  logic [1:0][31:0]  iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  ramstate_t         ramstate;
  bus_state_t        dbg_state;

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- RAM model ----------------
  logic [31:0] mem     [0:1023];
  logic        wr_flag [0:1023];
  int          ram_wait;
  bit          ram_err;
  int          ram_cnt;

  function automatic logic [31:0] ram_pat(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign ramload = (wr_flag[ramaddr[11:2]] === 1'b1) ? mem[ramaddr[11:2]] : ram_pat(ramaddr);

  always_comb begin
    if (ramREN || ramWEN)
      ramstate = (ram_cnt >= ram_wait) ? ACCESS : (ram_err ? ERROR : BUSY);
    else
      ramstate = FREE;
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < 1024; i++) wr_flag[i] <= 1'b0;
      ram_cnt <= 0;
    end else if (ramREN || ramWEN) begin
      if (ramstate == ACCESS) begin
        ram_cnt <= 0;
        if (ramWEN) begin
          mem[ramaddr[11:2]]     <= ramstore;
          wr_flag[ramaddr[11:2]] <= 1'b1;
        end
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else begin
      ram_cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_eq(tag, got, exp);
  endtask

  // Wait (bounded) for iwait/dwait[c] low; n = negedges skipped after the first.
  task automatic wait_low(input bit is_i, input int c, output int n);
    n = 0;
    @(negedge CLK);
    while (((is_i ? iwait[c] : dwait[c]) !== 1'b0) && n < 40) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 40) check_eq("wait_timeout", is_i ? iwait[c] : dwait[c], 32'd0);
  endtask

  task automatic drive_idle();
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"},  dbg_state, IDLE);
    check_eq({tag, "_iwait"},  iwait, 2'b11);
    check_eq({tag, "_dwait"},  dwait, 2'b11);
    check_eq({tag, "_iload"},  iload[0] | iload[1], 32'd0);
    check_eq({tag, "_dload"},  dload[0] | dload[1], 32'd0);
    check_eq({tag, "_ccwait"}, ccwait, 2'b00);
    check_eq({tag, "_ccinv"},  ccinv, 2'b00);
    check_eq({tag, "_snoop"},  ccsnoopaddr[0] | ccsnoopaddr[1], 32'd0);
    check_eq({tag, "_strb"},   {ramREN, ramWEN}, 2'b00);
    check_eq({tag, "_raddr"},  ramaddr, 32'd0);
    check_eq({tag, "_rstore"}, ramstore, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int n;

  initial begin
    drive_idle();
    nRST = 1'b0; ram_wait = 0; ram_err = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset, no requests
    @(negedge CLK);
    check_reset_outputs("rst");

    // IFETCH, CPU0 at 0x40, 2-wait RAM: completes on cycle 3
    @(posedge CLK); #1;
    ram_wait = 2; iREN[0] = 1'b1; iaddr[0] = 32'h40;
    exp_q.push_back(ram_pat(32'h40));
    wait_low(1'b1, 0, n);
    check_eq("ifetch_lat", n, 32'd3);
    pop_check("ifetch_iload", iload[0]);
    check_eq("ifetch_ren", ramREN, 1'b1);
    check_eq("ifetch_iwait1", iwait[1], 1'b1);
    @(posedge CLK); #1;
    iREN = '0;

    // WB, CPU1 block at 0x100, first word stalled by ERROR
    ram_wait = 2; ram_err = 1;
    dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h1111_AAAA;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("wb_state", dbg_state, WB);
    check_eq("wb_wen", ramWEN, 1'b1);
    check_eq("wb_addr", ramaddr, 32'h100);
    check_eq("wb_store", ramstore, 32'h1111_AAAA);
    check_eq("wb_err_stall", dwait[1], 1'b1);
    wait_low(1'b0, 1, n);
    check_eq("wb_lat0", n, 32'd1);
    @(posedge CLK); #1;
    ram_err = 0; ram_wait = 0; daddr[1] = 32'h104; dstore[1] = 32'h2222_BBBB;
    wait_low(1'b0, 1, n);
    check_eq("wb_lat1", n, 32'd0);
    @(posedge CLK); #1;
    dWEN = '0;
    @(negedge CLK);
    check_eq("wb_idle", dbg_state, IDLE);
    check_eq("wb_mem0", mem[32'h100 >> 2], 32'h1111_AAAA);
    check_eq("wb_mem1", mem[32'h104 >> 2], 32'h2222_BBBB);

    // MEMRD, CPU0 dREN at 0x200, CPU1 no M copy
    @(posedge CLK); #1;
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    exp_q.push_back(ram_pat(32'h200));
    exp_q.push_back(ram_pat(32'h204));
    @(negedge CLK);
    check_eq("mr_idle_ccwait", ccwait[1], 1'b0);
    @(negedge CLK);
    check_eq("mr_snoop_state", dbg_state, SNOOP);
    check_eq("mr_ccwait", ccwait[1], 1'b1);
    check_eq("mr_snaddr", ccsnoopaddr[1], 32'h200);
    check_eq("mr_ccinv", ccinv[1], 1'b0);
    check_eq("mr_snoop_strb", {ramREN, ramWEN}, 2'b00);
    wait_low(1'b0, 0, n);
    check_eq("mr_lat", n, 32'd0);
    pop_check("mr_dload0", dload[0]);
    check_eq("mr_ren", ramREN, 1'b1);
    check_eq("mr_ccwait_hold", ccwait[1], 1'b1);
    @(posedge CLK); #1;
    daddr[0] = 32'h204;
    wait_low(1'b0, 0, n);
    check_eq("mr_lat1", n, 32'd0);
    pop_check("mr_dload1", dload[0]);
    check_eq("mr_snaddr1", ccsnoopaddr[1], 32'h204);
    @(posedge CLK); #1;
    dREN = '0;
    @(negedge CLK);
    check_eq("mr_done", dbg_state, IDLE);
    check_eq("mr_done_ccwait", ccwait[1], 1'b0);

    // C2C, CPU0 dREN+ccwrite at 0x300, CPU1 holds M copy
    @(posedge CLK); #1;
    dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h300;
    cctrans[1] = 1'b1; dstore[1] = 32'h5A5A_0001;
    exp_q.push_back(32'h5A5A_0001);
    exp_q.push_back(32'h5A5A_0002);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("c2c_ccinv", ccinv[1], 1'b1);
    check_eq("c2c_ccwait", ccwait[1], 1'b1);
    wait_low(1'b0, 0, n);
    check_eq("c2c_lat", n, 32'd0);
    pop_check("c2c_dload0", dload[0]);
    check_eq("c2c_state", dbg_state, C2C);
    check_eq("c2c_wen", ramWEN, 1'b1);
    check_eq("c2c_store", ramstore, 32'h5A5A_0001);
    @(posedge CLK); #1;
    daddr[0] = 32'h304; dstore[1] = 32'h5A5A_0002;
    wait_low(1'b0, 0, n);
    pop_check("c2c_dload1", dload[0]);
    @(posedge CLK); #1;
    dREN = '0; ccwrite = '0; cctrans = '0;
    @(negedge CLK);
    check_eq("c2c_idle", dbg_state, IDLE);
    check_eq("c2c_mem0", mem[32'h300 >> 2], 32'h5A5A_0001);
    check_eq("c2c_mem1", mem[32'h304 >> 2], 32'h5A5A_0002);

    // Both cores dREN right after reset: CPU0 first, CPU1 snooped first
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h280;
    exp_q.push_back(ram_pat(32'h200));
    exp_q.push_back(ram_pat(32'h204));
    exp_q.push_back(ram_pat(32'h280));
    exp_q.push_back(ram_pat(32'h284));
    @(negedge CLK);
    @(negedge CLK);
    check_eq("tie_ccwait1", ccwait, 2'b10);
    check_eq("tie_snaddr1", ccsnoopaddr[1], 32'h200);
    wait_low(1'b0, 0, n);
    pop_check("tie_c0_w0", dload[0]);
    @(posedge CLK); #1 daddr[0] = 32'h204;
    wait_low(1'b0, 0, n);
    pop_check("tie_c0_w1", dload[0]);
    @(posedge CLK); #1 dREN[0] = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("tie_ccwait0", ccwait, 2'b01);
    check_eq("tie_snaddr0", ccsnoopaddr[0], 32'h280);
    wait_low(1'b0, 1, n);
    pop_check("tie_c1_w0", dload[1]);
    @(posedge CLK); #1 daddr[1] = 32'h284;
    wait_low(1'b0, 1, n);
    pop_check("tie_c1_w1", dload[1]);
    @(posedge CLK); #1 dREN = '0;
    check_eq("tie_q_empty", exp_q.size(), 32'd0);

    // Reset asserted mid-C2C (RAM stalled)
    ram_wait = 3;
    dREN[1] = 1'b1; daddr[1] = 32'h380; cctrans[0] = 1'b1; dstore[0] = 32'h0000_0077;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("mid_state", dbg_state, C2C);
    check_eq("mid_stall", dwait[1], 1'b1);
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("midrst");
    drive_idle();
    ram_wait = 0;
    @(posedge CLK); #1 nRST = 1'b1;

    // Upgrade: CPU1 cctrans+ccwrite at 0x80, no RAM traffic
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h80;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("upg_state", dbg_state, INVAL);
    check_eq("upg_ccinv", ccinv, 2'b01);
    check_eq("upg_ccwait", ccwait, 2'b01);
    check_eq("upg_snaddr", ccsnoopaddr[0], 32'h80);
    check_eq("upg_strb", {ramREN, ramWEN}, 2'b00);
    check_eq("upg_dwait", dwait, 2'b11);
    @(posedge CLK); #1 drive_idle();
    @(negedge CLK);
    check_eq("upg_idle", dbg_state, IDLE);
    check_eq("upg_ccinv_off", ccinv, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
